// File: rtl/fish_ctrl_pkg.sv
// rtl/fish_ctrl_pkg.sv - shared geometry, way encodings and state type for the fish controller
package fish_ctrl_pkg;

  localparam int SPRITE_W = 40;
  localparam int SPRITE_H = 35;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int EXIT_H   = 680;

  localparam logic [1:0] WAY_LEFT   = 2'd0;
  localparam logic [1:0] WAY_RIGHT  = 2'd1;
  localparam logic [1:0] WAY_HOOKED = 2'd2;

  typedef enum logic [1:0] {IDLE, SWIM_L, SWIM_R, HOOKED} state_t;

  // Hook point inside the swimming box h in [H-40, H-1], v in [V, V+34]; widened to avoid wrap.
  function automatic logic in_swim_box(input logic [9:0] h, input logic [9:0] v,
                                       input logic [9:0] px, input logic [9:0] py);
    return (({1'b0, px} + 11'(SPRITE_W)) >= {1'b0, h}) && (px < h) &&
           (py >= v) && ({1'b0, py} <= ({1'b0, v} + 11'(SPRITE_H - 1)));
  endfunction

endpackage

// File: rtl/fish_ctrl_if.sv
// rtl/fish_ctrl_if.sv - hook inputs and sprite outputs of the fish controller
interface fish_ctrl_if;

  logic [9:0] hook_x;
  logic [9:0] hook_y;
  logic       hook_down;
  logic [9:0] fish_h_position;
  logic [9:0] fish_v_position;
  logic [1:0] fish_way;
  logic       fish_appear;
  logic       caught;

  modport master (
    output hook_x, hook_y, hook_down,
    input  fish_h_position, fish_v_position, fish_way, fish_appear, caught
  );

  modport slave (
    input  hook_x, hook_y, hook_down,
    output fish_h_position, fish_v_position, fish_way, fish_appear, caught
  );

endinterface

// File: rtl/fish_ctrl_lfsr8.sv
// rtl/fish_ctrl_lfsr8.sv - free-running 8-bit Fibonacci LFSR, taps 8,6,5,4
module lfsr8 (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= 8'h5A;
    else     q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

endmodule

// File: rtl/fish_ctrl.sv
// rtl/fish_ctrl.sv - fish spawn/swim/hook/rise state machine driving the sprite renderer
module fish_ctrl
  import fish_ctrl_pkg::*;
#(
  parameter int SPEED_H     = 2,
  parameter int SPEED_UP    = 3,
  parameter int SPAWN_DELAY = 60,
  parameter int V_MIN       = 240,
  parameter int SURFACE_Y   = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        enable,
  fish_ctrl_if.slave  bus
);

  localparam logic [9:0]  SPD_H   = 10'(SPEED_H);
  localparam logic [9:0]  SPD_UP  = 10'(SPEED_UP);
  localparam logic [9:0]  CATCH_Y = 10'(SURFACE_Y + SPEED_UP);
  localparam logic [9:0]  EXIT_X  = 10'(EXIT_H);
  localparam logic [9:0]  H_MAX   = 10'(SCREEN_W - 1);
  localparam logic [15:0] DELAY   = 16'(SPAWN_DELAY);

  state_t      state_q, state_d;
  logic [9:0]  h_q, h_d, v_q, v_d;
  logic [1:0]  way_q, way_d;
  logic        appear_q, appear_d, caught_q, caught_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  rnd;
  logic        hit;
  logic [10:0] hook_sum;
  logic [9:0]  hook_h, v_up;

  lfsr8 u_lfsr (.clk(clk), .rst(rst), .q(rnd));

  assign hit      = bus.hook_down && in_swim_box(h_q, v_q, bus.hook_x, bus.hook_y);
  assign hook_sum = {1'b0, bus.hook_x} + 11'd17;
  assign hook_h   = (hook_sum > {1'b0, H_MAX}) ? H_MAX : hook_sum[9:0];
  assign v_up     = v_q - SPD_UP;

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    v_d      = v_q;
    way_d    = way_q;
    appear_d = appear_q;
    cnt_d    = cnt_q;
    caught_d = 1'b0;
    if (frame_tick && enable) begin
      case (state_q)
        IDLE: begin
          if (cnt_q == 16'd0) begin
            state_d  = rnd[0] ? SWIM_R : SWIM_L;
            h_d      = rnd[0] ? 10'd0 : EXIT_X;
            way_d    = rnd[0] ? WAY_RIGHT : WAY_LEFT;
            v_d      = 10'(V_MIN) + {3'b000, rnd[7:1]};
            appear_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        SWIM_L, SWIM_R: begin
          // The hit test uses the pre-move box and takes priority over leaving the screen.
          if (hit) begin
            state_d = HOOKED;
            way_d   = WAY_HOOKED;
            h_d     = hook_h;
            v_d     = bus.hook_y;
          end else if ((state_q == SWIM_L) ? (h_q <= SPD_H) : (h_q >= EXIT_X)) begin
            state_d  = IDLE;
            appear_d = 1'b0;
            cnt_d    = DELAY;
          end else begin
            h_d = (state_q == SWIM_L) ? (h_q - SPD_H) : (h_q + SPD_H);
          end
        end
        HOOKED: begin
          // Caught on the rise that lands within one step of the surface.
          v_d = v_up;
          if (v_up <= CATCH_Y) begin
            caught_d = 1'b1;
            state_d  = IDLE;
            appear_d = 1'b0;
            cnt_d    = DELAY;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      h_q      <= 10'd0;
      v_q      <= 10'd0;
      way_q    <= WAY_LEFT;
      appear_q <= 1'b0;
      caught_q <= 1'b0;
      cnt_q    <= DELAY;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      v_q      <= v_d;
      way_q    <= way_d;
      appear_q <= appear_d;
      caught_q <= caught_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.fish_h_position = h_q;
  assign bus.fish_v_position = v_q;
  assign bus.fish_way        = way_q;
  assign bus.fish_appear     = appear_q;
  assign bus.caught          = caught_q;

endmodule

// File: tb/tb_fish_ctrl.sv
// tb/tb_fish_ctrl.sv - directed self-checking bench for fish_ctrl
module tb_fish_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_tick = 1'b0;
  logic enable = 1'b0;

  fish_ctrl_if bus();

  fish_ctrl #(.SPAWN_DELAY(2)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .enable(enable), .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int caught_cnt = 0;
  logic [7:0] m_lfsr;

  // Reference LFSR: the value it holds at a negedge is what the DUT samples at the next posedge.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'h5A;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  always @(negedge clk) if (bus.caught === 1'b1) caught_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic spawn_with(input logic dir, input int lo, input int hi, output int v_exp);
    int n = 0;
    while (!(m_lfsr[0] == dir && int'(m_lfsr[7:1]) >= lo && int'(m_lfsr[7:1]) <= hi) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("spawn_lfsr_found", 32'(n < 600), 1);
    v_exp = 240 + int'(m_lfsr[7:1]);
    tick();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_appear"}, bus.fish_appear, 0);
    check({tag, "_way"}, bus.fish_way, 0);
    check({tag, "_h"}, bus.fish_h_position, 0);
    check({tag, "_v"}, bus.fish_v_position, 0);
    check({tag, "_caught"}, bus.caught, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    int v_exp;
    int k;
    logic got;
    bus.hook_x = 10'd0;
    bus.hook_y = 10'd0;
    bus.hook_down = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    enable = 1'b1;

    tick();
    check("idle_tick1_appear", bus.fish_appear, 0);
    tick();
    check("idle_tick2_appear", bus.fish_appear, 0);
    spawn_with(1'b0, 0, 127, v_exp);
    check("spawn_l_appear", bus.fish_appear, 1);
    check("spawn_l_way", bus.fish_way, 0);
    check("spawn_l_h", bus.fish_h_position, 680);
    check("spawn_l_v", bus.fish_v_position, v_exp);
    check("spawn_v_range", 32'(bus.fish_v_position >= 240 && bus.fish_v_position <= 367), 1);

    ticks(339);
    check("swim_l_h2", bus.fish_h_position, 2);
    check("swim_l_h2_appear", bus.fish_appear, 1);
    tick();
    check("swim_l_exit_appear", bus.fish_appear, 0);

    ticks(2);
    spawn_with(1'b1, 36, 70, v_exp);
    check("spawn_r_way", bus.fish_way, 1);
    check("spawn_r_h", bus.fish_h_position, 0);
    ticks(49);
    check("swim_r_h98", bus.fish_h_position, 98);
    bus.hook_x = 10'd98;
    bus.hook_y = 10'd310;
    bus.hook_down = 1'b1;
    tick();
    check("miss_edge_h", bus.fish_h_position, 100);
    check("miss_edge_way", bus.fish_way, 1);
    bus.hook_x = 10'd80;
    tick();
    bus.hook_down = 1'b0;
    check("hit_way", bus.fish_way, 2);
    check("hit_h", bus.fish_h_position, 97);
    check("hit_v", bus.fish_v_position, 310);
    check("hit_appear", bus.fish_appear, 1);

    tick();
    check("rise_v307", bus.fish_v_position, 307);
    k = 1;
    got = 1'b0;
    while (!got && k < 100) begin
      tick();
      k++;
      if (bus.caught === 1'b1) got = 1'b1;
    end
    check("caught_tick", k, 69);
    check("caught_appear", bus.fish_appear, 0);
    @(negedge clk);
    check("caught_one_cycle", bus.caught, 0);

    ticks(2);
    spawn_with(1'b1, 0, 127, v_exp);
    ticks(340);
    check("swim_r_h680", bus.fish_h_position, 680);
    bus.hook_x = 10'd660;
    bus.hook_y = 10'(v_exp + 5);
    bus.hook_down = 1'b1;
    tick();
    bus.hook_down = 1'b0;
    check("hit_exit_way", bus.fish_way, 2);
    check("hit_exit_h_clamp", bus.fish_h_position, 639);
    check("hit_exit_v", bus.fish_v_position, v_exp + 5);
    enable = 1'b0;
    ticks(5);
    check("frozen_h", bus.fish_h_position, 639);
    check("frozen_v", bus.fish_v_position, v_exp + 5);
    check("frozen_way", bus.fish_way, 2);
    check("frozen_appear", bus.fish_appear, 1);

    enable = 1'b1;
    ticks(3);
    check("rise_after_freeze_v", bus.fish_v_position, v_exp - 4);
    rst = 1'b1;
    @(negedge clk);
    check_reset("mid_rise_reset");
    rst = 1'b0;
    check("caught_total", caught_cnt, 1);
    ticks(2);
    check("post_reset_idle_appear", bus.fish_appear, 0);
    tick();
    check("post_reset_spawn_appear", bus.fish_appear, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fish_ctrl.md
FISH_CTRL -- requirements
Module: fish_ctrl

Interface
REQ-001 Parameter SPEED_H, default 2: horizontal pixels moved per frame_tick while swimming.
REQ-002 Parameter SPEED_UP, default 3: vertical pixels risen per frame_tick while hooked.
REQ-003 Parameter SPAWN_DELAY, default 60: frame_ticks spent absent before each spawn.
REQ-004 Parameter V_MIN, default 240: lowest spawn row offset (top edge of the fish box).
REQ-005 Parameter SURFACE_Y, default 100: row at or above which a hooked fish counts as caught.
REQ-006 clk  in  1  system clock; the only clock.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 frame_tick  in  1  one-cycle pulse per video frame; all motion advances only on it.
REQ-009 enable  in  1  game running; low freezes all state except the LFSR.
REQ-010 hook_x, hook_y  in  10 each  hook tip pixel coordinate.
REQ-011 hook_down  in  1  hook tip is in the water.
REQ-012 fish_h_position, fish_v_position  out  10 each  registered fish anchor for the sprite renderer.
REQ-013 fish_way  out  2  0 = swim left, 1 = swim right, 2 = hooked/rising.
REQ-014 fish_appear  out  1  fish is drawn.
REQ-015 caught  out  1  one-cycle pulse when a hooked fish reaches the surface.

Function
REQ-016 Box geometry: way 0/1 occupies h in [H-40, H-1] and v in [V, V+34]; way 2 occupies h in [H-34, H] and v in [V, V+79].
REQ-017 States: IDLE, SWIM_L, SWIM_R, HOOKED; fish_appear = 0 in IDLE only.
REQ-018 IDLE: each frame_tick with enable decrements the delay counter; on the tick where it is 0, the block spawns.
REQ-019 Spawn: lfsr[0]=0 -> SWIM_L, H=680, way 0; lfsr[0]=1 -> SWIM_R, H=0, way 1; V = V_MIN + lfsr[7:1] (range 240..367).
REQ-020 SWIM_L: each frame_tick sets H = H - SPEED_H; when H <= SPEED_H, the block goes to IDLE instead, reloading the counter to SPAWN_DELAY.
REQ-021 SWIM_R: each frame_tick sets H = H + SPEED_H; when H >= 680, the block goes to IDLE instead, reloading the counter.
REQ-022 Hit test, performed on frame_tick in SWIM_L/SWIM_R against the pre-move position: hook_down=1 and hook point inside the way-0/1 box.
REQ-023 Hit: next state HOOKED, way 2, H = min(hook_x + 17, 639), V = hook_y; no horizontal move on that tick.
REQ-024 Hit and exit on the same tick: the hit wins.
REQ-025 HOOKED: each frame_tick sets V = V - SPEED_UP; when V <= SURFACE_Y + SPEED_UP, caught pulses for one cycle, and the block goes to IDLE with the counter reloaded and fish_appear = 0 in the same update.
REQ-026 All outputs are registered and change only on the clk edge after frame_tick; the latency from frame_tick to position update is 1 cycle.
REQ-027 frame_tick with enable=0: no state, position or counter change; outputs hold.
REQ-028 The 8-bit Fibonacci LFSR (taps 8,6,5,4) advances every clk regardless of enable.
REQ-029 Arithmetic is 10-bit unsigned; no underflow is reachable given REQ-020 and REQ-025.

Reset
REQ-030 rst sets the following: state IDLE; fish_appear 0; fish_way 0; H 0; V 0; caught 0; delay counter SPAWN_DELAY; LFSR 8'h5A.
REQ-031 rst asserted mid-swim or mid-rise aborts the fish, and no caught pulse is produced.

Structure
REQ-032 Shared package holds the sprite dimensions (40, 35), the screen size (640x480), the way encodings, the exit bound 680, and the state enum.
REQ-033 One sub-module, lfsr8, provides the random source (ports clk, rst, q[7:0]).

Verification
REQ-034 Test: after reset, give SPAWN_DELAY=2, hold enable, and apply 3 frame_ticks -> spawn on tick 3 with fish_appear=1 and V in 240..367.
REQ-035 Test: force a SWIM_L spawn with SPEED_H=2 and apply 339 ticks -> H reaches 2, then IDLE with fish_appear=0 on the next tick.
REQ-036 Test: SWIM_R at H=100, V=300, and hook at (80, 310) with hook_down -> way=2, H=97, V=310 one cycle after the tick.
REQ-037 Test: HOOKED at V=310 with SPEED_UP=3 -> caught pulses exactly once, after 69 ticks, and fish_appear falls in the same cycle.
REQ-038 Test: hit and exit coincide, then enable=0 across 5 ticks -> HOOKED is taken, then the position stays frozen.
REQ-039 Test: rst asserted during HOOKED -> all outputs at reset values next cycle, and caught stays 0.
